// File: rtl/axi_pkg.sv
// Shared AXI constants and helpers for the read/write arbitration blocks.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arb_state_t;

   // AxSIZE encoding: log2 of the bytes per beat.
   function automatic logic [2:0] axi_size(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/axi_bus_rd_t.sv
// AXI read-channel bundle (AR + R) with master/slave views.
interface axi_bus_rd_t #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   parameter int ID_W   = 4
) ();
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [ID_W-1:0]   arid;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [ID_W-1:0]   rid;
   logic [1:0]        rresp;
   logic              rlast;

   modport master (
      output arvalid, araddr, arlen, arid, arsize, arburst, rready,
      input  arready, rvalid, rdata, rid, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arlen, arid, arsize, arburst, rready,
      output arready, rvalid, rdata, rid, rresp, rlast
   );
endinterface

// File: rtl/axi_rd_arbiter_chk.sv
// Elaboration-time parameter checks for axi_rd_arbiter.
module axi_rd_arbiter_chk #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 4
) ();
   if (ID_W < $clog2(NUM_REQ)) begin : g_id_too_narrow
      $error("axi_rd_arbiter: M_AXI_ID_WIDTH too small to carry requester index");
   end
endmodule

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1 with wrap.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic             en,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   logic             found_s;
   logic [IDX_W-1:0] cand_s;

   // Priority search starting just above the previous winner.
   always_comb begin
      found_s = 1'b0;
      cand_s  = '0;
      gnt_idx = '0;
      for (int k = 1; k <= N; k++) begin
         cand_s = IDX_W'((int'(last) + k) % N);
         if (!found_s && req[cand_s]) begin
            found_s = 1'b1;
            gnt_idx = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grant is only presented when the caller enables arbitration.
   always_comb begin
      gnt_onehot = '0;
      if (en && found_s) begin
         gnt_onehot[gnt_idx] = 1'b1;
         any                 = 1'b1;
      end else begin
         any = 1'b0;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master among NUM_REQ requesters: round-robin AR issue
// tagged by requester index, R beats demuxed back by rid.
module axi_rd_arbiter
   import axi_pkg::*;
#(
   parameter int NUM_REQ          = 4,
   parameter int M_AXI_ADDR_WIDTH = 64,
   parameter int M_AXI_DATA_WIDTH = 512,
   parameter int M_AXI_ID_WIDTH   = 4,
   parameter int MAX_OUTSTANDING  = 16
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_REQ-1:0]                        s_arvalid,
   output logic [NUM_REQ-1:0]                        s_arready,
   input  logic [NUM_REQ-1:0][M_AXI_ADDR_WIDTH-1:0]  s_araddr,
   input  logic [NUM_REQ-1:0][7:0]                   s_arlen,
   output logic [NUM_REQ-1:0]                        s_rvalid,
   input  logic [NUM_REQ-1:0]                        s_rready,
   output logic [M_AXI_DATA_WIDTH-1:0]               s_rdata,
   output logic                                      s_rlast,
   output logic [1:0]                                s_rresp,
   axi_bus_rd_t.master                               m_axi_rd,
   output logic                                      rid_err
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]        MAX_OUT_C   = CNT_W'(MAX_OUTSTANDING);
   localparam logic [M_AXI_ID_WIDTH:0] NUM_REQ_C   = (M_AXI_ID_WIDTH + 1)'(NUM_REQ);

   arb_state_t                  state_r;
   logic [M_AXI_ADDR_WIDTH-1:0] araddr_r;
   logic [7:0]                  arlen_r;
   logic [M_AXI_ID_WIDTH-1:0]   arid_r;
   logic                        arvalid_r;
   logic [IDX_W-1:0]            last_grant_r;
   logic [CNT_W-1:0]            outstanding_r;
   logic                        rid_err_r;

   logic                        grant_en_s;
   logic                        gnt_any_s;
   logic [IDX_W-1:0]            gnt_idx_s;
   logic [NUM_REQ-1:0]          gnt_onehot_s;
   logic                        ar_hs_s;
   logic                        r_last_hs_s;
   logic                        rid_ok_s;
   logic [IDX_W-1:0]            rid_idx_s;

   axi_rd_arbiter_chk #(.NUM_REQ(NUM_REQ), .ID_W(M_AXI_ID_WIDTH)) u_chk ();

   // Registered compare: a decrement this cycle only frees a slot next cycle.
   assign grant_en_s = (state_r == IDLE) && (outstanding_r < MAX_OUT_C);

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req        (s_arvalid),
      .en         (grant_en_s),
      .last       (last_grant_r),
      .gnt_onehot (gnt_onehot_s),
      .gnt_idx    (gnt_idx_s),
      .any        (gnt_any_s)
   );

   assign s_arready        = gnt_onehot_s;
   assign m_axi_rd.arvalid = arvalid_r;
   assign m_axi_rd.araddr  = araddr_r;
   assign m_axi_rd.arlen   = arlen_r;
   assign m_axi_rd.arid    = arid_r;
   assign m_axi_rd.arsize  = axi_size(M_AXI_DATA_WIDTH);
   assign m_axi_rd.arburst = AXI_BURST_INCR;

   assign ar_hs_s     = arvalid_r && m_axi_rd.arready;
   assign r_last_hs_s = m_axi_rd.rvalid && m_axi_rd.rready && m_axi_rd.rlast;
   assign rid_ok_s    = ({1'b0, m_axi_rd.rid} < NUM_REQ_C);
   assign rid_idx_s   = m_axi_rd.rid[IDX_W-1:0];

   assign s_rdata = m_axi_rd.rdata;
   assign s_rlast = m_axi_rd.rlast;
   assign s_rresp = m_axi_rd.rresp;
   assign rid_err = rid_err_r;

   // AR issue FSM: latch winner's request, then hold it on the master bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         araddr_r     <= '0;
         arlen_r      <= 8'd0;
         arid_r       <= '0;
         arvalid_r    <= 1'b0;
         last_grant_r <= IDX_W'(NUM_REQ - 1);
      end else begin
         case (state_r)
            IDLE: begin
               if (gnt_any_s) begin
                  araddr_r     <= s_araddr[gnt_idx_s];
                  arlen_r      <= s_arlen[gnt_idx_s];
                  arid_r       <= M_AXI_ID_WIDTH'(gnt_idx_s);
                  arvalid_r    <= 1'b1;
                  last_grant_r <= gnt_idx_s;
                  state_r      <= ISSUE;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               if (m_axi_rd.arready) begin
                  arvalid_r <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  state_r <= ISSUE;
               end
            end
            default: begin
               arvalid_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   // In-flight burst count: AR handshake adds one, final R beat retires one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_r <= '0;
      end else begin
         case ({ar_hs_s, r_last_hs_s})
            2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
            2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   // Sticky flag for beats carrying an id no requester owns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rid_err_r <= 1'b0;
      end else if (m_axi_rd.rvalid && !rid_ok_s) begin
         rid_err_r <= 1'b1;
      end else begin
         rid_err_r <= rid_err_r;
      end
   end

   // R demux; unknown ids are accepted and dropped so the bus never wedges.
   always_comb begin
      s_rvalid = '0;
      if (m_axi_rd.rvalid && rid_ok_s) begin
         s_rvalid[rid_idx_s] = 1'b1;
      end else begin
         s_rvalid = '0;
      end
      if (rid_ok_s) begin
         m_axi_rd.rready = s_rready[rid_idx_s];
      end else begin
         m_axi_rd.rready = 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: fairness, backpressure, R routing, bad id,
// reset mid-issue, and the outstanding cap on a second instance.
module tb_axi_rd_arbiter;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [3:0]            s_arvalid;
   logic [3:0][63:0]      s_araddr;
   logic [3:0][7:0]       s_arlen;
   logic [3:0]            s_rready;
   logic [3:0]            arrdy_a, arrdy_b, rvld_a, rvld_b;
   logic [511:0]          rdata_a, rdata_b;
   logic                  rlast_a, rlast_b, rerr_a, rerr_b;
   logic [1:0]            rresp_a, rresp_b;
   int                    checks = 0;
   int                    failures = 0;
   int                    rdy_cnt;

   always #5 clk = ~clk;

   axi_bus_rd_t #(.ADDR_W(64), .DATA_W(512), .ID_W(4)) bus_a ();
   axi_bus_rd_t #(.ADDR_W(64), .DATA_W(512), .ID_W(4)) bus_b ();

   axi_rd_arbiter dut (
      .clk(clk), .rst_n(rst_n), .s_arvalid(s_arvalid), .s_arready(arrdy_a),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_rvalid(rvld_a), .s_rready(s_rready),
      .s_rdata(rdata_a), .s_rlast(rlast_a), .s_rresp(rresp_a), .m_axi_rd(bus_a),
      .rid_err(rerr_a));

   axi_rd_arbiter #(.MAX_OUTSTANDING(2)) dut_cap (
      .clk(clk), .rst_n(rst_n), .s_arvalid(s_arvalid), .s_arready(arrdy_b),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_rvalid(rvld_b), .s_rready(s_rready),
      .s_rdata(rdata_b), .s_rlast(rlast_b), .s_rresp(rresp_b), .m_axi_rd(bus_b),
      .rid_err(rerr_b));

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      s_arvalid = 4'b0000;
      s_rready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         s_araddr[i] = 64'h100 * 64'(i);
         s_arlen[i]  = 8'(i);
      end
      bus_a.arready = 1'b1; bus_a.rvalid = 1'b0; bus_a.rid = 4'd0;
      bus_a.rdata = 512'h0; bus_a.rresp = 2'b00; bus_a.rlast = 1'b0;
      bus_b.arready = 1'b1; bus_b.rvalid = 1'b0; bus_b.rid = 4'd0;
      bus_b.rdata = 512'h0; bus_b.rresp = 2'b00; bus_b.rlast = 1'b0;
      repeat (3) tick();
      chk("rst_arvalid", 512'(bus_a.arvalid), 512'd0);
      chk("rst_s_arready", 512'(arrdy_a), 512'd0);
      chk("rst_rid_err", 512'(rerr_a), 512'd0);
      chk("rst_araddr", 512'(bus_a.araddr), 512'd0);

      // Fairness: all four requesting, downstream always ready.
      rst_n = 1'b1;
      s_arvalid = 4'b1111;
      #1;
      for (int g = 0; g < 8; g++) begin
         chk("fair_grant", 512'(arrdy_a), 512'(4'b0001 << (g % 4)));
         tick();
         #1;
         chk("fair_arvalid", 512'(bus_a.arvalid), 512'd1);
         chk("fair_arid", 512'(bus_a.arid), 512'(g % 4));
         chk("fair_araddr", 512'(bus_a.araddr), 512'(64'h100 * 64'(g % 4)));
         chk("fair_arlen", 512'(bus_a.arlen), 512'(g % 4));
         chk("fair_no_grant_in_issue", 512'(arrdy_a), 512'd0);
         tick();
         #1;
      end
      chk("arsize", 512'(bus_a.arsize), 512'd6);
      chk("arburst", 512'(bus_a.arburst), 512'd1);

      // Single requester keeps winning.
      s_arvalid = 4'b0010;
      #1;
      for (int g = 0; g < 3; g++) begin
         chk("single_grant", 512'(arrdy_a), 512'(4'b0010));
         tick();
         #1;
         chk("single_arid", 512'(bus_a.arid), 512'd1);
         tick();
         #1;
      end

      // Backpressure: requester 2 only, arready low for 5 cycles.
      s_arvalid = 4'b0100;
      s_araddr[2] = 64'h1000;
      s_arlen[2] = 8'd7;
      bus_a.arready = 1'b0;
      #1;
      rdy_cnt = 0;
      chk("bp_grant", 512'(arrdy_a), 512'(4'b0100));
      rdy_cnt += int'(arrdy_a[2]);
      tick();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_arvalid", 512'(bus_a.arvalid), 512'd1);
         chk("bp_araddr", 512'(bus_a.araddr), 512'h1000);
         chk("bp_arlen", 512'(bus_a.arlen), 512'd7);
         chk("bp_arid", 512'(bus_a.arid), 512'd2);
         rdy_cnt += int'(arrdy_a[2]);
         tick();
      end
      bus_a.arready = 1'b1;
      #1;
      chk("bp_release_arvalid", 512'(bus_a.arvalid), 512'd1);
      rdy_cnt += int'(arrdy_a[2]);
      tick();
      s_arvalid = 4'b0000;
      #1;
      chk("bp_arvalid_drop", 512'(bus_a.arvalid), 512'd0);
      chk("bp_arready_once", 512'(rdy_cnt), 512'd1);

      // R routing with requester 3 stalled.
      tick();
      bus_a.rvalid = 1'b1; bus_a.rid = 4'd1; bus_a.rdata = 512'hA5A5;
      bus_a.rlast = 1'b0; bus_a.rresp = 2'b00; s_rready = 4'b0111;
      #1;
      chk("r_id1_valid", 512'(rvld_a), 512'(4'b0010));
      chk("r_id1_rready", 512'(bus_a.rready), 512'd1);
      chk("r_rdata", rdata_a, 512'hA5A5);
      tick();
      bus_a.rid = 4'd3;
      #1;
      chk("r_id3_valid", 512'(rvld_a), 512'(4'b1000));
      chk("r_id3_stall", 512'(bus_a.rready), 512'd0);
      tick();
      bus_a.rid = 4'd1; bus_a.rlast = 1'b1; bus_a.rresp = 2'b10;
      #1;
      chk("r_id1b_valid", 512'(rvld_a), 512'(4'b0010));
      chk("r_rlast", 512'(rlast_a), 512'd1);
      chk("r_rresp", 512'(rresp_a), 512'(2'b10));

      // Out-of-range rid is dropped and flagged.
      tick();
      bus_a.rid = 4'd5; bus_a.rlast = 1'b0; bus_a.rresp = 2'b00;
      #1;
      chk("bad_rready", 512'(bus_a.rready), 512'd1);
      chk("bad_no_rvalid", 512'(rvld_a), 512'd0);
      chk("bad_err_not_yet", 512'(rerr_a), 512'd0);
      tick();
      bus_a.rvalid = 1'b0;
      #1;
      chk("bad_err_set", 512'(rerr_a), 512'd1);
      tick();
      #1;
      chk("bad_err_sticky", 512'(rerr_a), 512'd1);

      // Reset asserted while in ISSUE.
      s_arvalid = 4'b0001; bus_a.arready = 1'b0; s_rready = 4'b1111;
      #1;
      chk("rst_pre_grant", 512'(arrdy_a), 512'(4'b0001));
      tick();
      #1;
      chk("rst_pre_arvalid", 512'(bus_a.arvalid), 512'd1);
      rst_n = 1'b0; s_arvalid = 4'b0000;
      #1;
      chk("rst_mid_arvalid", 512'(bus_a.arvalid), 512'd0);
      chk("rst_mid_rid_err", 512'(rerr_a), 512'd0);
      chk("rst_mid_outstanding", 512'(dut.outstanding_r), 512'd0);
      tick();

      // Release; also the start of the cap sequence on dut_cap.
      rst_n = 1'b1; s_arvalid = 4'b0111; bus_a.arready = 1'b1;
      #1;
      chk("rst_first_grant", 512'(arrdy_a), 512'(4'b0001));
      chk("cap_c0_grant", 512'(arrdy_b), 512'(4'b0001));
      tick();
      s_arvalid = 4'b0110;
      #1;
      chk("cap_c1_arid", 512'(bus_b.arid), 512'd0);
      chk("cap_c1_arvalid", 512'(bus_b.arvalid), 512'd1);
      tick();
      #1;
      chk("cap_c2_grant", 512'(arrdy_b), 512'(4'b0010));
      tick();
      s_arvalid = 4'b0100;
      #1;
      chk("cap_c3_arid", 512'(bus_b.arid), 512'd1);
      tick();
      #1;
      chk("cap_c4_blocked", 512'(arrdy_b), 512'd0);
      chk("cap_c4_arvalid", 512'(bus_b.arvalid), 512'd0);
      tick();
      bus_b.rvalid = 1'b1; bus_b.rid = 4'd0; bus_b.rlast = 1'b1;
      #1;
      chk("cap_c5_still_blocked", 512'(arrdy_b), 512'd0);
      chk("cap_c5_rready", 512'(bus_b.rready), 512'd1);
      tick();
      bus_b.rvalid = 1'b0; bus_b.rlast = 1'b0;
      #1;
      chk("cap_c6_grant", 512'(arrdy_b), 512'(4'b0100));
      tick();
      s_arvalid = 4'b0000;
      #1;
      chk("cap_c7_arvalid", 512'(bus_b.arvalid), 512'd1);
      chk("cap_c7_arid", 512'(bus_b.arid), 512'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
